ex_stage: RTL
=============

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the decoded bundle from the ID/EX register: aluop, source operands, write address and write enable.
- Computes the ALU result and drives it combinationally back to the decode stage as the EX forwarding source.
- Registers the result into the EX/MEM boundary.
- Owns HI/LO and a 32-cycle iterative MULTU unit; requests a pipeline stall while the unit is busy.

Parameters:
- MUL_CYCLES, 32, shift-add iterations per MULTU; must equal data width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush_i  in  1  kill instruction in EX; abort multiply.
- aluop_i  in  8  operation code from ID/EX.
- rs_data_i  in  32  operand 1; register value, immediate or shift amount.
- rt_data_i  in  32  operand 2.
- w_reg_addr_i  in  5  destination register.
- wd_i  in  1  destination write enable.
- ex_data  out  32  combinational result, forwarding to decode.
- ex_wd_i  out  1  combinational write enable, forwarding to decode.
- ex_addr_i  out  5  combinational destination, forwarding to decode.
- mem_data  out  32  registered result to MEM.
- mem_wd  out  1  registered write enable to MEM.
- mem_addr  out  5  registered destination to MEM.
- stall_req  out  1  hold PC, IF/ID and ID/EX this cycle.

Behaviour:
- Reset:
  - Asynchronous, active-high. Applies immediately, including mid-multiply.
  - mem_data=0, mem_wd=0, mem_addr=0, HI=0, LO=0, FSM=IDLE, counter=0, stall_req=0.
- Result per aluop_i:
  - 0x21 ADDU: rs+rt mod 2^32; no overflow trap.
  - 0x24 AND: rs&rt.
  - 0x25 OR: rs|rt.
  - 0x26 XOR: rs^rt.
  - 0x0d ORI: rs|rt (rt already zero-extended).
  - 0x0f LUI: rt.
  - 0x00 SLL: rt << rs[4:0].
  - 0x10 MFHI: HI.
  - 0x12 MFLO: LO.
  - 0x04 BEQ: 0.
  - 0x19 MULTU: 0.
  - Any other code: 0.
- Forwarding outputs:
  - ex_data = result; ex_addr_i = w_reg_addr_i.
  - ex_wd_i = wd_i AND aluop_i is a known write-producing op AND NOT flush_i.
  - Unknown ops, BEQ and MULTU force ex_wd_i=0.
- EX/MEM register, on each rising edge:
  - flush_i=1 or stall_req=1: load bubble (mem_wd=0, mem_data=0, mem_addr=0).
  - Otherwise: load ex_data/ex_wd_i/ex_addr_i.
  - Latency from input to mem_*: 1 cycle.
- Multiply FSM states: IDLE, BUSY, DONE.
  - IDLE:
    - aluop_i=0x19 and flush_i=0: stall_req=1 combinationally this cycle.
    - On that edge: latch multiplicand=rs, multiplier=rt, acc=0, counter=0; go BUSY.
  - BUSY:
    - stall_req=1.
    - Each cycle: if multiplier[0], acc += multiplicand (64-bit).
    - Multiplicand shifts left 1; multiplier shifts right 1; counter increments.
    - When counter reaches MUL_CYCLES-1: {HI,LO} <= final acc on that edge; go DONE.
  - DONE:
    - stall_req=0; the held MULTU retires as a bubble.
    - Go IDLE unconditionally. MULTU is not re-triggered while in DONE.
  - Total stall: 33 cycles (start cycle + 32 BUSY).
  - MFHI/MFLO entering EX in the cycle after DONE read the new HI/LO.
- flush_i in BUSY: go IDLE next edge; HI/LO unchanged; stall_req drops that cycle.
- flush_i has priority over starting a multiply.
- Operands are sampled only at start. Input changes while BUSY are ignored; the pipeline holds them anyway.

Optional Feature:
- FAST_MUL_EN defined:
  - MULTU writes {HI,LO} = rs*rt (64-bit unsigned) on the edge it is in EX.
  - No FSM; stall_req tied 0.
  - flush_i suppresses the HI/LO write.
- FAST_MUL_EN undefined: iterative FSM exactly as above.

Test Plan:
- Reset mid-BUSY (rst pulse between edges) -> stall_req=0 immediately; HI=LO=0; mem_wd=0; FSM IDLE.
- ADDU rs=0xFFFFFFFF, rt=0x00000002, addr=5, wd=1 -> ex_data=0x00000001, ex_wd_i=1, ex_addr_i=5 same cycle; mem_data=0x00000001, mem_addr=5 next cycle.
- SLL rs=0x0000001F, rt=0x00000003 -> ex_data=0x80000000. LUI rt=0x12340000 -> ex_data=0x12340000.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF held; then MFHI, MFLO -> stall_req high exactly 33 cycles; MFHI=0xFFFFFFFE; MFLO=0x00000001; mem_wd=0 during stall.
- MULTU rs=3, rt=5, flush_i at BUSY cycle 10 -> FSM IDLE next edge; later MFLO returns prior LO (0 after reset).
- aluop 0x3F with wd_i=1 -> ex_wd_i=0, ex_data=0. FAST_MUL_EN build: MULTU 3*5 -> no stall; next-cycle MFLO=0x0000000F.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Computes the ALU result and forwards it combinationally to decode.
// Registers the result into the EX/MEM boundary.
// Owns HI/LO and an iterative shift-add MULTU unit that stalls the pipeline while busy.
// Build option: define FAST_MUL_EN to replace the iterative unit with a
// single-cycle multiplier. That build has no FSM and never stalls.
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic [4:0]  w_reg_addr_i,
  input  logic        wd_i,
  output logic [31:0] ex_data,
  output logic        ex_wd_i,
  output logic [4:0]  ex_addr_i,
  output logic [31:0] mem_data,
  output logic        mem_wd,
  output logic [4:0]  mem_addr,
  output logic        stall_req
);

  localparam logic [7:0] OP_SLL   = 8'h00;
  localparam logic [7:0] OP_BEQ   = 8'h04;
  localparam logic [7:0] OP_ORI   = 8'h0d;
  localparam logic [7:0] OP_LUI   = 8'h0f;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_ADDU  = 8'h21;
  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        stall;
  logic [31:0] result;
  logic        writes_reg;

  // Decode the operation into a result and whether it produces a register write.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    result     = '0;
    writes_reg = 1'b0;
    unique case (aluop_i)
      OP_ADDU: begin result = rs_data_i + rt_data_i;           writes_reg = 1'b1; end
      OP_AND:  begin result = rs_data_i & rt_data_i;           writes_reg = 1'b1; end
      OP_OR:   begin result = rs_data_i | rt_data_i;           writes_reg = 1'b1; end
      OP_XOR:  begin result = rs_data_i ^ rt_data_i;           writes_reg = 1'b1; end
      OP_ORI:  begin result = rs_data_i | rt_data_i;           writes_reg = 1'b1; end
      OP_LUI:  begin result = rt_data_i;                       writes_reg = 1'b1; end
      OP_SLL:  begin result = rt_data_i << rs_data_i[4:0];     writes_reg = 1'b1; end
      OP_MFHI: begin result = hi_q;                            writes_reg = 1'b1; end
      OP_MFLO: begin result = lo_q;                            writes_reg = 1'b1; end
      default: begin result = '0;                              writes_reg = 1'b0; end
    endcase
  end

  assign ex_data   = result;
  assign ex_wd_i   = wd_i & writes_reg & ~flush_i;
  assign ex_addr_i = w_reg_addr_i;
  assign stall_req = stall;

`ifdef FAST_MUL_EN

  // Single-cycle multiply: write HI/LO on the edge MULTU sits in EX, unless it is flushed.
  always_comb begin
    stall = 1'b0;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (aluop_i == OP_MULTU && !flush_i) begin
      {hi_d, lo_d} = {32'd0, rs_data_i} * {32'd0, rt_data_i};
    end
  end

`else

  localparam int CNT_W = $clog2(MUL_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } mul_state_e;

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      mcand_q, mcand_d;
  logic [31:0]      mplier_q, mplier_d;
  logic [63:0]      acc_q, acc_d;
  logic [63:0]      acc_sum;

  // Partial-product accumulation for the current multiplier bit.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : 64'd0);

  // Multiply FSM next state. Stall is requested from the start cycle through the last BUSY cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    stall    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (aluop_i == OP_MULTU && !flush_i) begin
          stall    = 1'b1;
          state_d  = S_BUSY;
          mcand_d  = {32'd0, rs_data_i};
          mplier_d = rt_data_i;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          // Aborted multiply: HI/LO keep their old contents.
          state_d = S_IDLE;
        end else begin
          stall    = 1'b1;
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
            {hi_d, lo_d} = acc_sum;
            state_d      = S_DONE;
          end
        end
      end
      S_DONE: begin
        // The held MULTU is still on the inputs. It retires here without restarting.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Multiply datapath and FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

`endif

  // HI/LO architectural registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // EX/MEM boundary. A bubble is loaded while flushed or stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data <= '0;
      mem_wd   <= 1'b0;
      mem_addr <= '0;
    end else if (flush_i || stall) begin
      mem_data <= '0;
      mem_wd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_data <= ex_data;
      mem_wd   <= ex_wd_i;
      mem_addr <= ex_addr_i;
    end
  end

endmodule
